agh_socfpga_io_ctrl: RTL and testbench

Parametrised Avalon-MM I/O controller in the FPGA fabric, behind the HPS lightweight bridge. It drives a configurable bank of LEDs and samples a configurable bank of board inputs (KEY/SW). Each input is synchronised and debounced, and programmable rising/falling edges are captured into an interrupt-generating status register. It supersedes the fixed 8-LED output-only peripheral.

---
 rtl/agh_socfpga_io_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_agh_socfpga_io_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/agh_socfpga_io_ctrl.sv
// agh_socfpga_io_ctrl
// Avalon-MM I/O controller behind the HPS lightweight bridge. Drives a bank
// of LEDs and samples a bank of board inputs (KEY/SW) through a 2-FF
// synchroniser and a per-bit debounce counter. Stable rising/falling edges
// are captured into a W1C status register that raises a level interrupt.
//
// Optional feature macro: AGH_IO_LED_PWM_EN
//   defined   -> 8-bit free-running PWM dims the LEDs via PWM_DUTY (addr 6)
//   undefined -> led follows LED_OUT directly; addr 6 reads 0, ignores writes
module agh_socfpga_io_ctrl #(
  parameter int N_LEDS          = 8,
  parameter int N_INPUTS        = 6,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  output logic [31:0]         avs_readdata,
  output logic                irq,
  input  logic [N_INPUTS-1:0] in_raw,
  output logic [N_LEDS-1:0]   led
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0]   ID_VALUE = 32'h4147_0100 | (32'(N_INPUTS) << 4'd8) | 32'(N_LEDS);

  localparam logic [2:0] ADDR_LED_OUT  = 3'd0;
  localparam logic [2:0] ADDR_IN_STATE = 3'd1;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd2;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd5;
  localparam logic [2:0] ADDR_PWM_DUTY = 3'd6;
  localparam logic [2:0] ADDR_ID       = 3'd7;

  // Register file
  logic [N_LEDS-1:0]   led_out_r;
  logic [N_INPUTS-1:0] edge_cap_r;
  logic [N_INPUTS-1:0] irq_mask_r;
  logic [N_INPUTS-1:0] rise_en_r;
  logic [N_INPUTS-1:0] fall_en_r;

  // Input path
  logic [N_INPUTS-1:0] sync1_r;
  logic [N_INPUTS-1:0] sync2_r;
  logic [N_INPUTS-1:0] stable_r;
  logic [CW-1:0]       cnt_r [N_INPUTS];

  // Outputs
  logic [31:0]         readdata_r;
  logic                irq_r;
  logic [N_LEDS-1:0]   led_r;

  // Combinational helpers
  logic                we_led_s;
  logic                we_cap_s;
  logic                we_mask_s;
  logic                we_rise_s;
  logic                we_fall_s;
  logic                we_pwm_s;
  logic [N_INPUTS-1:0] accept_s;
  logic [N_INPUTS-1:0] rise_s;
  logic [N_INPUTS-1:0] fall_s;
  logic [N_INPUTS-1:0] w1c_s;
  logic [31:0]         rdata_s;
  logic                unused_wdata_s;

`ifdef AGH_IO_LED_PWM_EN
  logic [7:0] pwm_duty_r;
  logic [7:0] pwm_cnt_r;
  logic       pwm_on_s;
`endif

  assign avs_readdata   = readdata_r;
  assign irq            = irq_r;
  assign led            = led_r;
  // Bits of writedata above the implemented register widths are don't-care.
  assign unused_wdata_s = ^avs_writedata;

  // Write-enable decode: one strobe per writable register.
  always_comb begin
    we_led_s  = 1'b0;
    we_cap_s  = 1'b0;
    we_mask_s = 1'b0;
    we_rise_s = 1'b0;
    we_fall_s = 1'b0;
    we_pwm_s  = 1'b0;
    case (avs_address)
      ADDR_LED_OUT:  we_led_s  = avs_write;
      ADDR_EDGE_CAP: we_cap_s  = avs_write;
      ADDR_IRQ_MASK: we_mask_s = avs_write;
      ADDR_RISE_EN:  we_rise_s = avs_write;
      ADDR_FALL_EN:  we_fall_s = avs_write;
      ADDR_PWM_DUTY: we_pwm_s  = avs_write;
      default:       we_led_s  = 1'b0;
    endcase
  end

  // Debounce acceptance and qualified edge events, valid in the cycle the stable level flips.
  always_comb begin
    accept_s = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      accept_s[i] = (sync2_r[i] != stable_r[i]) && (cnt_r[i] == CNT_MAX);
    end
    rise_s = accept_s &  sync2_r & rise_en_r;
    fall_s = accept_s & ~sync2_r & fall_en_r;
    w1c_s  = we_cap_s ? avs_writedata[N_INPUTS-1:0] : '0;
  end

  // Read mux; unimplemented bits return 0.
  always_comb begin
    rdata_s = 32'h0;
    case (avs_address)
      ADDR_LED_OUT:  rdata_s[N_LEDS-1:0]   = led_out_r;
      ADDR_IN_STATE: rdata_s[N_INPUTS-1:0] = stable_r;
      ADDR_EDGE_CAP: rdata_s[N_INPUTS-1:0] = edge_cap_r;
      ADDR_IRQ_MASK: rdata_s[N_INPUTS-1:0] = irq_mask_r;
      ADDR_RISE_EN:  rdata_s[N_INPUTS-1:0] = rise_en_r;
      ADDR_FALL_EN:  rdata_s[N_INPUTS-1:0] = fall_en_r;
`ifdef AGH_IO_LED_PWM_EN
      ADDR_PWM_DUTY: rdata_s[7:0]          = pwm_duty_r;
`else
      ADDR_PWM_DUTY: rdata_s               = 32'h0;
`endif
      ADDR_ID:       rdata_s               = ID_VALUE;
      default:       rdata_s               = 32'h0;
    endcase
  end

  // Synchronise inputs and debounce: a new level must persist DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r  <= '0;
      sync2_r  <= '0;
      stable_r <= '0;
      for (int i = 0; i < N_INPUTS; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= in_raw;
      sync2_r <= sync1_r;
      for (int i = 0; i < N_INPUTS; i++) begin
        if (sync2_r[i] == stable_r[i]) begin
          cnt_r[i] <= '0;
        end else if (accept_s[i]) begin
          cnt_r[i]    <= '0;
          stable_r[i] <= sync2_r[i];
        end else begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end
      end
    end
  end

  // Software-visible registers; a new edge beats a same-cycle W1C on that bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_out_r  <= '0;
      edge_cap_r <= '0;
      irq_mask_r <= '0;
      rise_en_r  <= '0;
      fall_en_r  <= '0;
    end else begin
      if (we_led_s) begin
        led_out_r <= avs_writedata[N_LEDS-1:0];
      end
      if (we_mask_s) begin
        irq_mask_r <= avs_writedata[N_INPUTS-1:0];
      end
      if (we_rise_s) begin
        rise_en_r <= avs_writedata[N_INPUTS-1:0];
      end
      if (we_fall_s) begin
        fall_en_r <= avs_writedata[N_INPUTS-1:0];
      end
      edge_cap_r <= (edge_cap_r & ~w1c_s) | rise_s | fall_s;
    end
  end

  // Read data register: latency 1, held between reads, pre-write value on collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readdata_r <= 32'h0;
    end else if (avs_read) begin
      readdata_r <= rdata_s;
    end
  end

  // Level interrupt from masked captured edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= |(edge_cap_r & irq_mask_r);
    end
  end

`ifdef AGH_IO_LED_PWM_EN
  assign pwm_on_s = (pwm_duty_r == 8'hFF) || (pwm_cnt_r < pwm_duty_r);

  // PWM duty register and free-running brightness counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_duty_r <= 8'hFF;
      pwm_cnt_r  <= 8'h00;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + 8'd1;
      if (we_pwm_s) begin
        pwm_duty_r <= avs_writedata[7:0];
      end
    end
  end

  // Registered LED drive gated by the PWM window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r <= '0;
    end else begin
      led_r <= led_out_r & {N_LEDS{pwm_on_s}};
    end
  end
`else
  // Registered LED drive straight from LED_OUT (PWM strobe has no target here).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r <= '0;
    end else begin
      led_r <= led_out_r | ({N_LEDS{we_pwm_s}} & '0);
    end
  end
`endif

endmodule

// File: tb/tb_agh_socfpga_io_ctrl.sv
// Self-checking bench for agh_socfpga_io_ctrl with DEBOUNCE_CYCLES=16.
// A table of write/readback vectors covers the register map; hand-written
// sequences cover debounce timing, edge capture, the W1C/set collision,
// asynchronous reset and (when AGH_IO_LED_PWM_EN is defined) PWM dimming.
module tb_agh_socfpga_io_ctrl;

  localparam int          N_LEDS   = 8;
  localparam int          N_INPUTS = 6;
  localparam int          DEB      = 16;
  localparam logic [31:0] ID_EXP   = 32'h4147_0708;
  localparam int          NV       = 12;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [2:0]          avs_address = 3'd0;
  logic                avs_read = 1'b0;
  logic                avs_write = 1'b0;
  logic [31:0]         avs_writedata = 32'h0;
  logic [31:0]         avs_readdata;
  logic                irq;
  logic [N_INPUTS-1:0] in_raw = '0;
  logic [N_LEDS-1:0]   led;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        chk_led;
    logic [7:0]  exp_led;
  } vec_t;

  vec_t vecs [NV];

  agh_socfpga_io_ctrl #(
    .N_LEDS(N_LEDS),
    .N_INPUTS(N_INPUTS),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .avs_address(avs_address),
    .avs_read(avs_read),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata),
    .irq(irq),
    .in_raw(in_raw),
    .led(led)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read    = 1'b0;
    d           = avs_readdata;
  endtask

  task automatic vec(input int i, input logic [2:0] a, input logic [31:0] w,
                     input logic [31:0] e, input logic cl, input logic [7:0] el);
    vecs[i].addr    = a;
    vecs[i].wdata   = w;
    vecs[i].exp_rd  = e;
    vecs[i].chk_led = cl;
    vecs[i].exp_led = el;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdata;
    int          k;
    int          hi;

    vec(0,  3'd0, 32'h0000_00A5, 32'h0000_00A5, 1'b1, 8'hA5);
    vec(1,  3'd0, 32'hFFFF_FF00, 32'h0000_0000, 1'b1, 8'h00);
    vec(2,  3'd0, 32'h0000_005A, 32'h0000_005A, 1'b1, 8'h5A);
    vec(3,  3'd3, 32'hFFFF_FFFF, 32'h0000_003F, 1'b0, 8'h00);
    vec(4,  3'd3, 32'h0000_0000, 32'h0000_0000, 1'b0, 8'h00);
    vec(5,  3'd4, 32'h0000_0015, 32'h0000_0015, 1'b0, 8'h00);
    vec(6,  3'd4, 32'h0000_0000, 32'h0000_0000, 1'b0, 8'h00);
    vec(7,  3'd5, 32'hFFFF_FFC0, 32'h0000_0000, 1'b0, 8'h00);
    vec(8,  3'd1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 8'h00);
    vec(9,  3'd7, 32'h1234_5678, ID_EXP,        1'b0, 8'h00);
    vec(10, 3'd2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 8'h00);
`ifdef AGH_IO_LED_PWM_EN
    vec(11, 3'd6, 32'hFFFF_FF40, 32'h0000_0040, 1'b0, 8'h00);
`else
    vec(11, 3'd6, 32'hFFFF_FF40, 32'h0000_0000, 1'b0, 8'h00);
`endif

    // Reset state
    #12;
    check("reset_led", 32'(led), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_readdata", avs_readdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Register map vectors
    for (int i = 0; i < NV; i++) begin
      wr(vecs[i].addr, vecs[i].wdata);
      if (vecs[i].chk_led) begin
        @(negedge clk);
        check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
      end
      rd(vecs[i].addr, rdata);
      check($sformatf("vec%0d_rd", i), rdata, vecs[i].exp_rd);
    end
`ifdef AGH_IO_LED_PWM_EN
    wr(3'd6, 32'h0000_00FF);
`endif

    // Simultaneous read and write at address 0 returns the pre-write value
    @(negedge clk);
    avs_address   = 3'd0;
    avs_writedata = 32'h0000_003C;
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    check("rw_collision_old", avs_readdata, 32'h0000_005A);
    rd(3'd0, rdata);
    check("rw_collision_new", rdata, 32'h0000_003C);
    repeat (3) @(negedge clk);
    check("readdata_hold", avs_readdata, 32'h0000_003C);
    check("led_after_rw", 32'(led), 32'h0000_003C);

    // 10-cycle glitch on bit 2 never reaches IN_STATE
    @(negedge clk);
    in_raw[2] = 1'b1;
    repeat (10) @(negedge clk);
    in_raw[2] = 1'b0;
    repeat (30) @(negedge clk);
    rd(3'd1, rdata);
    check("glitch_in_state", rdata, 32'h0);

    // Held level: IN_STATE flips 18 cycles after the pin, visible one read later
    wr(3'd4, 32'h0000_0004);
    wr(3'd3, 32'h0000_0004);
    @(negedge clk);
    avs_address = 3'd1;
    avs_read    = 1'b1;
    in_raw[2]   = 1'b1;
    repeat (18) @(negedge clk);
    check("deb_in_state_early", avs_readdata, 32'h0);
    check("deb_irq_early", 32'(irq), 32'h0);
    @(negedge clk);
    check("deb_in_state_on_time", avs_readdata, 32'h0000_0004);
    check("deb_irq_on_time", 32'(irq), 32'h1);
    avs_read = 1'b0;
    rd(3'd2, rdata);
    check("deb_edge_cap", rdata, 32'h0000_0004);
    wr(3'd2, 32'h0000_0004);
    @(negedge clk);
    check("w1c_bit2_irq", 32'(irq), 32'h0);

    // Rising edge on bit 0 with RISE_EN=1, IRQ_MASK=1
    wr(3'd4, 32'h0000_0001);
    wr(3'd3, 32'h0000_0001);
    @(negedge clk);
    in_raw[0] = 1'b1;
    k = 0;
    while (irq !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("edge0_irq_latency", 32'(k), 32'd19);
    rd(3'd2, rdata);
    check("edge0_edge_cap", rdata, 32'h0000_0001);
    rd(3'd1, rdata);
    check("edge0_in_state", rdata, 32'h0000_0005);
    wr(3'd2, 32'h0000_0001);
    @(negedge clk);
    check("edge0_w1c_irq", 32'(irq), 32'h0);

    // Set beats W1C on the same bit in the same cycle
    wr(3'd5, 32'h0000_0002);
    @(negedge clk);
    in_raw[1] = 1'b1;
    repeat (25) @(negedge clk);
    rd(3'd2, rdata);
    check("rise_disabled_bit1", rdata, 32'h0);
    @(negedge clk);
    in_raw[1] = 1'b0;
    repeat (17) @(negedge clk);
    avs_address   = 3'd2;
    avs_writedata = 32'h0000_0002;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write     = 1'b0;
    rd(3'd2, rdata);
    check("collision_set_wins", rdata, 32'h0000_0002);
    check("masked_bit1_irq", 32'(irq), 32'h0);
    wr(3'd3, 32'h0000_0003);
    @(negedge clk);
    check("mask_write_irq", 32'(irq), 32'h1);
    wr(3'd2, 32'h0000_0002);
    rd(3'd2, rdata);
    check("w1c_bit1", rdata, 32'h0);

    // Asynchronous reset with EDGE_CAP=3 and irq high
    wr(3'd4, 32'h0000_0003);
    wr(3'd5, 32'h0000_0003);
    wr(3'd0, 32'h0000_00FF);
    @(negedge clk);
    in_raw[0] = 1'b0;
    in_raw[1] = 1'b1;
    repeat (25) @(negedge clk);
    rd(3'd2, rdata);
    check("pre_reset_edge_cap", rdata, 32'h0000_0003);
    check("pre_reset_irq", 32'(irq), 32'h1);
    check("pre_reset_led", 32'(led), 32'h0000_00FF);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_irq", 32'(irq), 32'h0);
    check("async_reset_led", 32'(led), 32'h0);
    check("async_reset_readdata", avs_readdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(3'd2, rdata);
    check("post_reset_edge_cap", rdata, 32'h0);
    rd(3'd7, rdata);
    check("post_reset_id", rdata, ID_EXP);
    rd(3'd0, rdata);
    check("post_reset_led_out", rdata, 32'h0);
    repeat (25) @(negedge clk);
    rd(3'd1, rdata);
    check("post_reset_in_state", rdata, 32'h0000_0006);
    rd(3'd2, rdata);
    check("post_reset_no_capture", rdata, 32'h0);

`ifdef AGH_IO_LED_PWM_EN
    // PWM duty sweep on led[0]
    wr(3'd0, 32'h0000_0001);
    wr(3'd6, 32'h0000_0040);
    @(negedge clk);
    hi = 0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      if (led[0]) hi++;
    end
    check("pwm_duty64", 32'(hi), 32'd64);
    wr(3'd6, 32'h0000_00FF);
    @(negedge clk);
    hi = 0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      if (led[0]) hi++;
    end
    check("pwm_duty255", 32'(hi), 32'd256);
    wr(3'd6, 32'h0000_0000);
    @(negedge clk);
    hi = 0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      if (led[0]) hi++;
    end
    check("pwm_duty0", 32'(hi), 32'd0);
`else
    hi = 0;
    wr(3'd6, 32'h0000_0040);
    rd(3'd6, rdata);
    check("pwm_addr6_zero", rdata, 32'(hi));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
